bus_sram_slave: RTL and testbench

//   Word-addressed on-chip SRAM slave that sits directly downstream of the

---
 rtl/bus_sram_slave.sv | 131 +++++++++++++
 tb/tb_bus_sram_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_slave.sv
// rtl/bus_sram_slave.sv - word-addressed SRAM slave for the picorv32 native bus
// Fixed-latency responses, byte-lane writes, sticky out-of-range flag, fetch/data counters.
module bus_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_valid,
  input  logic             bus_instr,
  output logic             bus_ready,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_rdata,
  output logic             err_oor,
  input  logic             err_clr,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] data_cnt
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_INIT = 3'(LATENCY - 1);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_wait;
  logic [AW-1:0] r_idx;
  logic          r_oor;
  logic          r_instr;
  logic          r_read;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [31:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_to_resp;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_read;
  logic          w_rd_oor;

  // Comparing the full byte offset against the byte span avoids discarding addr[1:0].
  assign w_off      = bus_addr - ADDR_BASE;
  assign w_in_range = (bus_addr >= ADDR_BASE) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[AW+1:2];
  assign w_accept   = (r_state == S_IDLE) && bus_valid;
  assign w_to_resp  = (w_accept && (WAIT_INIT == 3'd0)) ||
                      ((r_state == S_WAIT) && (r_wait == 3'd1));

  // With LATENCY=1 the response is loaded straight from the live request.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_idx : r_idx;
  assign w_rd_read = (r_state == S_IDLE) ? (bus_wstrb == 4'b0000) : r_read;
  assign w_rd_oor  = (r_state == S_IDLE) ? !w_in_range : r_oor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus_valid) w_next = (WAIT_INIT == 3'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_wait == 3'd1) w_next = S_RESP;
      S_RESP: w_next = S_TURN;
      S_TURN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_ready = 1'b0;
    if (r_state == S_RESP) bus_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= w_idx;
      r_oor   <= !w_in_range;
      r_instr <= bus_instr;
      r_read  <= (bus_wstrb == 4'b0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait    <= 3'd0;
      bus_rdata <= 32'h0000_0000;
      err_oor   <= 1'b0;
      fetch_cnt <= '0;
      data_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_wait <= WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        r_wait <= r_wait - 3'd1;
      end
      if (w_to_resp && w_rd_read) begin
        bus_rdata <= w_rd_oor ? 32'h0000_0000 : r_mem[w_rd_idx];
      end
      if ((r_state == S_RESP) && r_oor) begin
        err_oor <= 1'b1;
      end else if (err_clr) begin
        err_oor <= 1'b0;
      end
      if (r_state == S_RESP) begin
        if (r_instr) fetch_cnt <= fetch_cnt + 1'b1;
        else         data_cnt  <= data_cnt + 1'b1;
      end
    end
  end

  // Writes commit at capture so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_wstrb[b]) r_mem[w_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb/tb_bus_sram_slave.sv - bench for bus_sram_slave
// Instance 0: base 0, 4096 words, latency 1. Instance 1: base 0x100, 16 words, latency 4, 2-bit counters.
module tb_bus_sram_slave;

  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        valid [2];
  logic        instr [2];
  logic        clr   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic        err   [2];
  logic [31:0] rdata [2];
  logic [15:0] fcnt_a, dcnt_a;
  logic [1:0]  fcnt_b, dcnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [longint];
  int          exp_f   [2];
  int          exp_d   [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];

  always #5 clk = ~clk;

  bus_sram_slave #(.ADDR_BASE(32'h0), .DEPTH_WORDS(4096), .LATENCY(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst[0]), .bus_valid(valid[0]), .bus_instr(instr[0]), .bus_ready(ready[0]),
    .bus_addr(addr[0]), .bus_wdata(wdata[0]), .bus_wstrb(wstrb[0]), .bus_rdata(rdata[0]),
    .err_oor(err[0]), .err_clr(clr[0]), .fetch_cnt(fcnt_a), .data_cnt(dcnt_a));

  bus_sram_slave #(.ADDR_BASE(BASE_B), .DEPTH_WORDS(16), .LATENCY(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst[1]), .bus_valid(valid[1]), .bus_instr(instr[1]), .bus_ready(ready[1]),
    .bus_addr(addr[1]), .bus_wdata(wdata[1]), .bus_wstrb(wstrb[1]), .bus_rdata(rdata[1]),
    .err_oor(err[1]), .err_clr(clr[1]), .fetch_cnt(fcnt_b), .data_cnt(dcnt_b));

  function automatic longint base_of(int d);
    return (d == 1) ? longint'(BASE_B) : 64'd0;
  endfunction

  function automatic bit in_rng(int d, logic [31:0] a);
    longint depth = (d == 1) ? 16 : 4096;
    return (longint'(a) >= base_of(d)) && ((longint'(a) - base_of(d)) / 4 < depth);
  endfunction

  function automatic longint key(int d, logic [31:0] a);
    return (longint'(d) << 40) + (longint'(a) - base_of(d)) / 4;
  endfunction

  function automatic void model_apply(int d, logic [31:0] a, logic [31:0] wd, logic [3:0] ws, logic ins);
    longint k;
    logic [31:0] w;
    if (ins) exp_f[d]++;
    else     exp_d[d]++;
    if (!in_rng(d, a)) begin
      exp_err[d] = 1'b1;
      if (ws == 4'b0000) exp_rd[d] = 32'h0;
      return;
    end
    k = key(d, a);
    w = mdl.exists(k) ? mdl[k] : 32'h0;
    if (ws == 4'b0000) begin
      exp_rd[d] = w;
    end else begin
      for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      mdl[k] = w;
    end
  endfunction

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst[d] = 1'b1; valid[d] = 1'b0; clr[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    exp_f[d] = 0; exp_d[d] = 0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0;
  endtask

  // Drives one request, then scrambles the inputs while waiting; returns in the TURN cycle.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins, output int lat);
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws; instr[d] = ins;
    lat = 0;
    @(negedge clk);
    lat = 1;
    valid[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom;
    wstrb[d] = 4'($urandom); instr[d] = 1'($urandom);
    while (ready[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) reset_dut(d);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", d, ready[d]); end
      n_cmp++; if (rdata[d] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", d, rdata[d]); end
      n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d] got=%b exp=0", d, err[d]); end
    end
    n_cmp++; if ({fcnt_a, dcnt_a, fcnt_b, dcnt_b} !== 36'h0) begin n_bad++; $display("FAIL reset_cnt got=%h/%h/%h/%h exp=0", fcnt_a, dcnt_a, fcnt_b, dcnt_b); end
  endtask

  task automatic test_write_read;
    int lat;
    access(0, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, lat); model_apply(0, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    access(0, 32'h10, 32'h0, 4'h0, 1'b0, lat); model_apply(0, 32'h10, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    n_cmp++; if (rdata[0] !== 32'hCAFEBABE) begin n_bad++; $display("FAIL rd_data got=%h exp=cafebabe", rdata[0]); end
  endtask

  task automatic test_strobe;
    int lat;
    access(0, 32'h20, 32'h11223344, 4'hF, 1'b0, lat); model_apply(0, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat); model_apply(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    n_cmp++; if (rdata[0] !== 32'hCAFEBABE) begin n_bad++; $display("FAIL wr_hold_rdata got=%h exp=cafebabe", rdata[0]); end
    access(0, 32'h20, 32'h0, 4'h0, 1'b0, lat); model_apply(0, 32'h20, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (rdata[0] !== 32'h11BB33DD) begin n_bad++; $display("FAIL strobe_data got=%h exp=11bb33dd", rdata[0]); end
  endtask

  task automatic test_random;
    int lat, d, exp_lat;
    logic [31:0] a, wd;
    logic [3:0] ws;
    logic ins;
    for (int i = 0; i < 16; i++) begin
      d = i / 8;
      a = 32'(base_of(d)) + 32'(4 * (i % 8));
      wd = $urandom;
      access(d, a, wd, 4'hF, 1'b0, lat); model_apply(d, a, wd, 4'hF, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      d = $urandom_range(0, 1);
      exp_lat = (d == 1) ? 4 : 1;
      a = 32'(base_of(d)) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = (d == 1) ? ($urandom_range(0, 1) ? BASE_B - 4 : BASE_B + 64) : 32'h4000 + 32'(4 * $urandom_range(0, 3));
      wd = $urandom;
      ws = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      ins = 1'($urandom);
      access(d, a, wd, ws, ins, lat); model_apply(d, a, wd, ws, ins);
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rand_lat[%0d] dut=%0d got=%0d exp=%0d", i, d, lat, exp_lat); end
      n_cmp++; if (rdata[d] !== exp_rd[d]) begin n_bad++; $display("FAIL rand_rdata[%0d] dut=%0d addr=%h got=%h exp=%h", i, d, a, rdata[d], exp_rd[d]); end
      n_cmp++; if (err[d] !== exp_err[d]) begin n_bad++; $display("FAIL rand_err[%0d] dut=%0d got=%b exp=%b", i, d, err[d], exp_err[d]); end
    end
    n_cmp++; if (fcnt_a !== 16'(exp_f[0]) || dcnt_a !== 16'(exp_d[0])) begin n_bad++; $display("FAIL rand_cnt_a got=%0d/%0d exp=%0d/%0d", fcnt_a, dcnt_a, 16'(exp_f[0]), 16'(exp_d[0])); end
    n_cmp++; if (fcnt_b !== 2'(exp_f[1]) || dcnt_b !== 2'(exp_d[1])) begin n_bad++; $display("FAIL rand_cnt_b got=%0d/%0d exp=%0d/%0d", fcnt_b, dcnt_b, 2'(exp_f[1]), 2'(exp_d[1])); end
  endtask

  task automatic test_back_to_back;
    logic expv;
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = BASE_B; wstrb[1] = 4'h0; instr[1] = 1'b0; wdata[1] = 32'h0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      expv = (k == 4 || k == 10 || k == 16);
      n_cmp++; if (ready[1] !== expv) begin n_bad++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", k, ready[1], expv); end
      if (k == 17) valid[1] = 1'b0;
    end
    for (int j = 0; j < 3; j++) model_apply(1, BASE_B, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (rdata[1] !== exp_rd[1]) begin n_bad++; $display("FAIL b2b_rdata got=%h exp=%h", rdata[1], exp_rd[1]); end
  endtask

  task automatic test_oor;
    int lat;
    access(0, 32'h4000, 32'h0, 4'h0, 1'b0, lat); model_apply(0, 32'h4000, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL oor_lat got=%0d exp=1", lat); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_bad++; $display("FAIL oor_rdata got=%h exp=0", rdata[0]); end
    n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL oor_err got=%b exp=1", err[0]); end
    clr[0] = 1'b1;
    access(0, 32'h4004, 32'h12345678, 4'hF, 1'b0, lat); model_apply(0, 32'h4004, 32'h12345678, 4'hF, 1'b0);
    n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL oor_set_wins got=%b exp=1", err[0]); end
    @(negedge clk);
    clr[0] = 1'b0; exp_err[0] = 1'b0;
    n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL oor_clear got=%b exp=0", err[0]); end
    access(1, BASE_B - 4, 32'h0, 4'h0, 1'b0, lat); model_apply(1, BASE_B - 4, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (rdata[1] !== 32'h0 || err[1] !== 1'b1 || lat !== 4) begin n_bad++; $display("FAIL oor_below got=%h/%b/%0d exp=0/1/4", rdata[1], err[1], lat); end
    access(1, BASE_B + 64, 32'hDEADBEEF, 4'hF, 1'b0, lat); model_apply(1, BASE_B + 64, 32'hDEADBEEF, 4'hF, 1'b0);
    access(1, BASE_B, 32'h0, 4'h0, 1'b0, lat); model_apply(1, BASE_B, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (rdata[1] !== exp_rd[1]) begin n_bad++; $display("FAIL oor_write_dropped got=%h exp=%h", rdata[1], exp_rd[1]); end
  endtask

  task automatic test_counters;
    int lat;
    reset_dut(0);
    for (int i = 0; i < 3; i++) begin access(0, 32'h10, 32'h0, 4'h0, 1'b1, lat); model_apply(0, 32'h10, 32'h0, 4'h0, 1'b1); end
    for (int i = 0; i < 2; i++) begin access(0, 32'h24, 32'h0BAD0000 + 32'(i), 4'hF, 1'b0, lat); model_apply(0, 32'h24, 32'h0BAD0000 + 32'(i), 4'hF, 1'b0); end
    n_cmp++; if (fcnt_a !== 16'd3) begin n_bad++; $display("FAIL fetch_cnt got=%0d exp=3", fcnt_a); end
    n_cmp++; if (dcnt_a !== 16'd2) begin n_bad++; $display("FAIL data_cnt got=%0d exp=2", dcnt_a); end
    reset_dut(1);
    for (int i = 0; i < 5; i++) begin access(1, BASE_B, 32'h0, 4'h0, 1'b1, lat); model_apply(1, BASE_B, 32'h0, 4'h0, 1'b1); end
    n_cmp++; if (fcnt_b !== 2'd1 || dcnt_b !== 2'd0) begin n_bad++; $display("FAIL fetch_wrap got=%0d/%0d exp=1/0", fcnt_b, dcnt_b); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses;
    access(1, BASE_B + 4, 32'h5A5A0001, 4'hF, 1'b0, lat); model_apply(1, BASE_B + 4, 32'h5A5A0001, 4'hF, 1'b0);
    access(1, BASE_B + 64, 32'h0, 4'h0, 1'b0, lat); model_apply(1, BASE_B + 64, 32'h0, 4'h0, 1'b0);
    access(1, BASE_B + 4, 32'h0, 4'h0, 1'b1, lat); model_apply(1, BASE_B + 4, 32'h0, 4'h0, 1'b1);
    n_cmp++; if (rdata[1] !== 32'h5A5A0001 || err[1] !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%h/%b exp=5a5a0001/1", rdata[1], err[1]); end
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = BASE_B + 8; wdata[1] = 32'h77665544; wstrb[1] = 4'hF; instr[1] = 1'b0;
    model_apply(1, BASE_B + 8, 32'h77665544, 4'hF, 1'b0);
    @(negedge clk);
    valid[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    exp_f[1] = 0; exp_d[1] = 0; exp_err[1] = 1'b0; exp_rd[1] = 32'h0;
    n_cmp++; if ({ready[1], rdata[1], err[1], fcnt_b, dcnt_b} !== 38'h0) begin n_bad++; $display("FAIL mid_reset got=%b/%h/%b/%0d/%0d exp=all zero", ready[1], rdata[1], err[1], fcnt_b, dcnt_b); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ready[1] === 1'b1) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_no_ready got=%0d exp=0", pulses); end
    access(1, BASE_B + 8, 32'h0, 4'h0, 1'b0, lat); model_apply(1, BASE_B + 8, 32'h0, 4'h0, 1'b0);
    n_cmp++; if (lat !== 4 || rdata[1] !== exp_rd[1]) begin n_bad++; $display("FAIL mid_after got=%0d/%h exp=4/%h", lat, rdata[1], exp_rd[1]); end
    n_cmp++; if (dcnt_b !== 2'(exp_d[1])) begin n_bad++; $display("FAIL mid_after_cnt got=%0d exp=%0d", dcnt_b, 2'(exp_d[1])); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; instr[d] = 1'b0; clr[d] = 1'b0;
      addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
      exp_f[d] = 0; exp_d[d] = 0; exp_err[d] = 1'b0; exp_rd[d] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_strobe();
    test_random();
    test_back_to_back();
    test_oor();
    test_counters();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
